// File: rtl/simon_pkg.sv
// Shared constants, state type and word-level helpers for the iterative Simon engine.
// Word helpers operate on 64-bit containers holding an n-bit word in the LSBs.
package simon_pkg;

    // z_j sequences, leftmost bit (bit 61) is z_j[0]
    localparam logic [61:0] Z [0:4] = '{
        62'b11111010001001010110000111001101111101000100101011000011100110,
        62'b10001110111110010011000010110101000111011111001001100001011010,
        62'b10101111011100000011010010011000101000010001111110010110110011,
        62'b11011011101011000110010111100000010010001010011100110100001111,
        62'b11010001111001101011011000100000010111000011001010010011101111
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        KEXP = 2'd1,
        RUN  = 2'd2,
        HOLD = 2'd3
    } state_t;

    function automatic logic [63:0] word_mask(input int n);
        return (n >= 64) ? {64{1'b1}} : ((64'd1 << n) - 64'd1);
    endfunction

    function automatic logic [63:0] rol(input logic [63:0] a, input int s, input int n);
        return ((a << s) | (a >> (n - s))) & word_mask(n);
    endfunction

    function automatic logic [63:0] ror(input logic [63:0] a, input int s, input int n);
        return rol(a, n - s, n);
    endfunction

    function automatic logic [63:0] simon_f(input logic [63:0] a, input int n);
        return (rol(a, 1, n) & rol(a, 8, n)) ^ rol(a, 2, n);
    endfunction

endpackage

// File: rtl/simon_key_expand.sv
// Simon key schedule generator: streams k[0..T-1] as RAM writes, one word per cycle,
// from a sliding M-word window loaded with the user key.
module simon_key_expand
    import simon_pkg::*;
#(
    parameter int N    = 64,
    parameter int M    = 4,
    parameter int T    = 72,
    parameter int ZSEQ = 4,
    parameter int AW   = $clog2(T)
) (
    input  logic           clk,
    input  logic           res,
    input  logic           start,
    input  logic [M*N-1:0] key,
    output logic           we,
    output logic [AW-1:0]  addr,
    output logic [N-1:0]   word,
    output logic           done
);

    localparam logic [61:0] ZROW = Z[ZSEQ];
    localparam int          K3   = (M >= 3) ? M - 3 : 0;

    logic [M-1:0][N-1:0] sr;
    logic [AW-1:0]       cnt;
    logic [5:0]          zcnt;
    logic                active;
    logic                loading;
    logic [N-1:0]        tmp;
    logic [N-1:0]        gen;

    // sr[0] is k[i-M], sr[M-1] is k[i-1]
    always_comb begin
        tmp = N'(ror(64'(sr[M-1]), 3, N));
        if (M == 4) tmp = tmp ^ sr[K3];
        tmp = tmp ^ N'(ror(64'(tmp), 1, N));
        gen = ~sr[0] ^ tmp ^ N'(ZROW[6'd61 - zcnt]) ^ N'(3);
    end

    // During the first M cycles the window rotates so the user words are written out unchanged
    assign loading = (cnt < AW'(M));
    assign we      = active;
    assign addr    = cnt;
    assign word    = loading ? sr[0] : gen;
    assign done    = active && (cnt == AW'(T - 1));

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            sr     <= '0;
            cnt    <= '0;
            zcnt   <= '0;
            active <= 1'b0;
        end else if (start) begin
            sr     <= key;
            cnt    <= '0;
            zcnt   <= '0;
            active <= 1'b1;
        end else if (active) begin
            sr <= {word, sr[M-1:1]};
            if (done) begin
                active <= 1'b0;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (!loading) zcnt <= (zcnt == 6'd61) ? 6'd0 : zcnt + 1'b1;
        end
    end

endmodule

// File: rtl/simon_engine.sv
// Iterative Simon encrypt/decrypt engine, one round per clock, with an internal
// round-key RAM filled by a key expansion pass so many blocks can share one key load.
//
// state | meaning
// IDLE  | waiting for a key or a block; key for round 0 is prefetched
// KEXP  | key schedule being written into the RAM, T cycles
// RUN   | T rounds, one per cycle
// HOLD  | result registered and offered until taken
module simon_engine
    import simon_pkg::*;
#(
    parameter int N    = 64,
    parameter int M    = 4,
    parameter int T    = 72,
    parameter int ZSEQ = 4
) (
    input  logic           clk,
    input  logic           res,
    input  logic           key_valid,
    output logic           key_ready,
    input  logic [M*N-1:0] key_in,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           in_dec,
    input  logic [2*N-1:0] in_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] out_data,
    output logic           key_ok
);

    localparam int            AW   = $clog2(T);
    localparam logic [AW-1:0] LAST = AW'(T - 1);

    state_t        state, state_nx;
    logic          key_acc, blk_acc, last_rnd;
    logic          kx_we, kx_done;
    logic [AW-1:0] kx_addr, rd_addr, ram_addr;
    logic [N-1:0]  kx_word, rk;
    logic [N-1:0]  x, y, fx, fy;
    logic          dec;
    logic [AW-1:0] rnd;
    logic [N-1:0]  ram [0:T-1];

    simon_key_expand #(.N(N), .M(M), .T(T), .ZSEQ(ZSEQ), .AW(AW)) u_kexp (
        .clk   (clk),
        .res   (res),
        .start (key_acc),
        .key   (key_in),
        .we    (kx_we),
        .addr  (kx_addr),
        .word  (kx_word),
        .done  (kx_done)
    );

    assign last_rnd = (rnd == LAST);

    always_ff @(posedge clk or posedge res) begin
        if (res) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        key_ready = 1'b0;
        in_ready  = 1'b0;
        key_acc   = 1'b0;
        blk_acc   = 1'b0;
        case (state)
            IDLE: begin
                key_ready = ~out_valid;
                in_ready  = key_ok & ~out_valid & ~key_valid;
                if (key_valid && key_ready) begin
                    key_acc  = 1'b1;
                    state_nx = KEXP;
                end else if (in_valid && in_ready) begin
                    blk_acc  = 1'b1;
                    state_nx = RUN;
                end
            end
            KEXP:    if (kx_done) state_nx = IDLE;
            RUN:     if (last_rnd) state_nx = HOLD;
            HOLD:    if (out_valid && out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Registered read: the address issued now is the key for the next round
    always_comb begin
        rd_addr = '0;
        if (state == RUN) begin
            if (!last_rnd) rd_addr = dec ? (LAST - 1'b1 - rnd) : (rnd + 1'b1);
        end else begin
            rd_addr = in_dec ? LAST : '0;
        end
    end

    assign ram_addr = kx_we ? kx_addr : rd_addr;

    always_ff @(posedge clk) begin
        if (kx_we) ram[ram_addr] <= kx_word;
        rk <= ram[ram_addr];
    end

    assign fx = N'(simon_f(64'(x), N));
    assign fy = N'(simon_f(64'(y), N));

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            key_ok    <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            x         <= '0;
            y         <= '0;
            dec       <= 1'b0;
            rnd       <= '0;
        end else begin
            if (key_acc)      key_ok <= 1'b0;
            else if (kx_done) key_ok <= 1'b1;

            if (blk_acc) begin
                x   <= in_data[2*N-1:N];
                y   <= in_data[N-1:0];
                dec <= in_dec;
                rnd <= '0;
            end else if (state == RUN) begin
                if (dec) begin
                    x <= y;
                    y <= x ^ fy ^ rk;
                end else begin
                    x <= y ^ fx ^ rk;
                    y <= x;
                end
                rnd <= last_rnd ? '0 : rnd + 1'b1;
            end

            if (state == HOLD && !out_valid) begin
                out_valid <= 1'b1;
                out_data  <= {x, y};
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_simon_engine.sv
// Bench for simon_engine: three configurations share the stimulus buses; results are
// checked against known-answer vectors and a full-schedule software model of Simon.
module tb_simon_engine;

    localparam logic [61:0] ZT [0:4] = '{
        62'b11111010001001010110000111001101111101000100101011000011100110,
        62'b10001110111110010011000010110101000111011111001001100001011010,
        62'b10101111011100000011010010011000101000010001111110010110110011,
        62'b11011011101011000110010111100000010010001010011100110100001111,
        62'b11010001111001101011011000100000010111000011001010010011101111
    };
    localparam int CN [0:2] = '{64, 64, 32};
    localparam int CM [0:2] = '{4, 2, 4};
    localparam int CT [0:2] = '{72, 68, 44};
    localparam int CZ [0:2] = '{4, 2, 3};

    localparam logic [255:0] K4  = 256'h1f1e1d1c1b1a1918_1716151413121110_0f0e0d0c0b0a0908_0706050403020100;
    localparam logic [127:0] PT4 = 128'h74206e69206d6f6f_6d69732061207369;
    localparam logic [127:0] CT4 = 128'h8d2b5579afc8a3a0_3bf72a87efe7b868;
    localparam logic [255:0] K2  = 256'h0f0e0d0c0b0a0908_0706050403020100;
    localparam logic [127:0] PT2 = 128'h6373656420737265_6c6c657661727420;
    localparam logic [127:0] CT2 = 128'h49681b1e1e54fe3f_65aa832af84e0bbc;
    localparam logic [255:0] K3  = 256'h1b1a1918_13121110_0b0a0908_03020100;
    localparam logic [127:0] PT3 = 128'h656b696c_20646e75;
    localparam logic [127:0] CT3 = 128'h44c8fc20_b9dfa07a;

    typedef struct {
        logic [1:0]   cfg;
        logic [255:0] key;
        logic         dec;
        logic [127:0] din;
        logic [127:0] exp;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         res;
    logic [255:0] key_bus;
    logic [127:0] din_bus;
    logic         dec_bus;
    logic         out_ready;
    logic [2:0]   kv, iv, kr, ir, ov, kok;
    logic [127:0] od0, od1;
    logic [63:0]  od2;
    logic [1:0]   sel;
    logic         c_kr, c_ir, c_ov, c_kok;
    logic [127:0] c_od;
    int           total = 0;
    int           bad = 0;

    simon_engine #(.N(64), .M(4), .T(72), .ZSEQ(4)) dut0 (
        .clk(clk), .res(res), .key_valid(kv[0]), .key_ready(kr[0]), .key_in(key_bus),
        .in_valid(iv[0]), .in_ready(ir[0]), .in_dec(dec_bus), .in_data(din_bus),
        .out_valid(ov[0]), .out_ready(out_ready), .out_data(od0), .key_ok(kok[0]));

    simon_engine #(.N(64), .M(2), .T(68), .ZSEQ(2)) dut1 (
        .clk(clk), .res(res), .key_valid(kv[1]), .key_ready(kr[1]), .key_in(key_bus[127:0]),
        .in_valid(iv[1]), .in_ready(ir[1]), .in_dec(dec_bus), .in_data(din_bus),
        .out_valid(ov[1]), .out_ready(out_ready), .out_data(od1), .key_ok(kok[1]));

    simon_engine #(.N(32), .M(4), .T(44), .ZSEQ(3)) dut2 (
        .clk(clk), .res(res), .key_valid(kv[2]), .key_ready(kr[2]), .key_in(key_bus[127:0]),
        .in_valid(iv[2]), .in_ready(ir[2]), .in_dec(dec_bus), .in_data(din_bus[63:0]),
        .out_valid(ov[2]), .out_ready(out_ready), .out_data(od2), .key_ok(kok[2]));

    always_comb begin
        c_kr  = kr[sel];
        c_ir  = ir[sel];
        c_ov  = ov[sel];
        c_kok = kok[sel];
        c_od  = (sel == 2'd0) ? od0 : (sel == 2'd1) ? od1 : {64'd0, od2};
    end

    function automatic logic [63:0] rl(input logic [63:0] a, input int s, input int n);
        logic [63:0] mask;
        mask = (n == 64) ? {64{1'b1}} : ((64'd1 << n) - 64'd1);
        return ((a << s) | (a >> (n - s))) & mask;
    endfunction

    function automatic logic [63:0] ff(input logic [63:0] a, input int n);
        return (rl(a, 1, n) & rl(a, 8, n)) ^ rl(a, 2, n);
    endfunction

    function automatic logic [127:0] model(input logic [1:0] s, input logic [255:0] key,
                                           input logic dec, input logic [127:0] blk);
        logic [63:0] k [0:71];
        logic [63:0] mask, x, y, tmp, nx;
        int n, m, t;
        n = CN[s]; m = CM[s]; t = CT[s];
        mask = (n == 64) ? {64{1'b1}} : ((64'd1 << n) - 64'd1);
        for (int i = 0; i < m; i++) k[i] = 64'(key >> (i * n)) & mask;
        for (int i = m; i < t; i++) begin
            tmp = rl(k[i-1], n - 3, n);
            if (m == 4) tmp = tmp ^ k[i-3];
            tmp = tmp ^ rl(tmp, n - 1, n);
            k[i] = (~k[i-m] ^ tmp ^ 64'(ZT[CZ[s]][61 - ((i - m) % 62)]) ^ 64'd3) & mask;
        end
        x = 64'(blk >> n) & mask;
        y = 64'(blk) & mask;
        if (!dec) begin
            for (int r = 0; r < t; r++) begin nx = y ^ ff(x, n) ^ k[r]; y = x; x = nx; end
        end else begin
            for (int r = t - 1; r >= 0; r--) begin nx = x ^ ff(y, n) ^ k[r]; x = y; y = nx; end
        end
        return (128'(x) << n) | 128'(y);
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v = {v[223:0], 32'($urandom)};
        return v;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic load_key(input logic [1:0] s, input logic [255:0] k);
        int n;
        sel = s;
        @(negedge clk);
        n = 0;
        while (!c_kr && n < 300) begin @(negedge clk); n++; end
        key_bus = k;
        kv[s] = 1'b1;
        @(negedge clk);
        kv[s] = 1'b0;
        n = 0;
        while (!c_kok && n < 300) begin @(negedge clk); n++; end
        check($sformatf("key_ok after load cfg%0d", s), c_kok, 1'b1);
    endtask

    // Returns with out_valid seen high; completes the transfer when out_ready is set
    task automatic run_block(input logic [1:0] s, input logic d, input logic [127:0] din,
                             output logic [127:0] dout, output int lat);
        int n;
        sel = s;
        @(negedge clk);
        n = 0;
        while (!c_ir && n < 300) begin @(negedge clk); n++; end
        din_bus = din;
        dec_bus = d;
        iv[s] = 1'b1;
        @(negedge clk);
        iv[s] = 1'b0;
        lat = 0;
        while (!c_ov && lat < 300) begin @(posedge clk); lat++; @(negedge clk); end
        check($sformatf("out_valid seen cfg%0d", s), c_ov, 1'b1);
        dout = c_od;
        if (out_ready) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vec_t         tbl [0:5];
        logic [127:0] dout, d, exp;
        logic [255:0] kr_rand;
        logic         flag;
        int           lat, n;

        res = 1'b1; kv = '0; iv = '0; key_bus = '0; din_bus = '0; dec_bus = 1'b0;
        out_ready = 1'b1; sel = 2'd0;
        repeat (3) @(negedge clk);
        check("rst key_ok", c_kok, 1'b0);
        check("rst out_valid", c_ov, 1'b0);
        check("rst in_ready", c_ir, 1'b0);
        check("rst key_ready", c_kr, 1'b1);
        check("rst out_data", c_od, '0);
        res = 1'b0;
        @(negedge clk);

        // block offered with no key loaded
        din_bus = PT4; iv[0] = 1'b1; flag = 1'b0;
        repeat (12) begin @(negedge clk); if (ir[0] || ov[0]) flag = 1'b1; end
        iv[0] = 1'b0;
        check("no key: in_ready/out_valid", flag, 1'b0);

        tbl[0] = '{2'd0, K4, 1'b0, PT4, CT4};
        tbl[1] = '{2'd0, K4, 1'b1, CT4, PT4};
        tbl[2] = '{2'd1, K2, 1'b0, PT2, CT2};
        tbl[3] = '{2'd1, K2, 1'b1, CT2, PT2};
        tbl[4] = '{2'd2, K3, 1'b0, PT3, CT3};
        tbl[5] = '{2'd2, K3, 1'b1, CT3, PT3};
        for (int i = 0; i < 6; i++) begin
            load_key(tbl[i].cfg, tbl[i].key);
            run_block(tbl[i].cfg, tbl[i].dec, tbl[i].din, dout, lat);
            check($sformatf("kat%0d data", i), dout, tbl[i].exp);
            check($sformatf("kat%0d latency", i), lat, CT[tbl[i].cfg] + 1);
        end

        // back-to-back random blocks, alternating modes, on the Simon128/256 instance
        for (int i = 0; i < 8; i++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            run_block(2'd0, i[0], d, dout, lat);
            check($sformatf("rand128/256 #%0d", i), dout, model(2'd0, K4, i[0], d));
        end

        // random keys and blocks on the other two configurations
        for (int s = 1; s < 3; s++) begin
            kr_rand = rnd256();
            load_key(2'(s), kr_rand);
            for (int i = 0; i < 3; i++) begin
                d = {$urandom, $urandom, $urandom, $urandom};
                if (s == 2) d[127:64] = '0;
                run_block(2'(s), 1'($urandom_range(0, 1)), d, dout, lat);
                check($sformatf("rand cfg%0d #%0d", s, i), dout, model(2'(s), kr_rand, dec_bus, d));
            end
        end

        // consumer stalls for 20 cycles
        out_ready = 1'b0;
        d = {$urandom, $urandom, $urandom, $urandom};
        run_block(2'd0, 1'b0, d, dout, lat);
        flag = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (c_od !== dout || c_ir || c_kr || !c_ov) flag = 1'b0;
        end
        check("stall: stable and not ready", flag, 1'b1);
        check("stall: data", dout, model(2'd0, K4, 1'b0, d));
        out_ready = 1'b1;
        @(negedge clk);
        check("after transfer out_valid", c_ov, 1'b0);
        check("after transfer in_ready", c_ir, 1'b1);

        // key and block offered together: key wins, block waits for the new schedule
        kr_rand = rnd256();
        d = {$urandom, $urandom, $urandom, $urandom};
        key_bus = kr_rand; kv[0] = 1'b1; din_bus = d; dec_bus = 1'b0; iv[0] = 1'b1;
        #1;
        check("key wins: in_ready", c_ir, 1'b0);
        @(negedge clk);
        kv[0] = 1'b0;
        check("kexp: key_ok low", c_kok, 1'b0);
        check("kexp: in_ready low", c_ir, 1'b0);
        n = 0;
        while (!c_ir && n < 300) begin @(negedge clk); n++; end
        check("deferred block accepted", c_ir, 1'b1);
        @(negedge clk);
        iv[0] = 1'b0;
        lat = 0;
        while (!c_ov && lat < 300) begin @(posedge clk); lat++; @(negedge clk); end
        check("deferred block data", c_od, model(2'd0, kr_rand, 1'b0, d));
        @(negedge clk);

        // reset during round 30
        load_key(2'd0, K4);
        n = 0;
        while (!c_ir && n < 300) begin @(negedge clk); n++; end
        din_bus = PT4; dec_bus = 1'b0; iv[0] = 1'b1;
        @(negedge clk);
        iv[0] = 1'b0;
        repeat (30) @(posedge clk);
        #2 res = 1'b1;
        #1;
        check("mid reset key_ok", c_kok, 1'b0);
        check("mid reset out_valid", c_ov, 1'b0);
        check("mid reset in_ready", c_ir, 1'b0);
        check("mid reset key_ready", c_kr, 1'b1);
        check("mid reset out_data", c_od, '0);
        @(negedge clk);
        res = 1'b0;
        load_key(2'd0, K4);
        run_block(2'd0, 1'b0, PT4, dout, lat);
        check("post reset kat data", dout, CT4);
        check("post reset kat latency", lat, 73);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
